// File: rtl/kb_pkg.sv
// Shared types and scan-code constants for the keyboard event sequencer.
package kb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        DECODE = 2'd2
    } kb_state_e;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic [7:0] LSHIFT  = 8'h12;
    localparam logic [7:0] RSHIFT  = 8'h59;
    localparam logic [7:0] CTRL    = 8'h14;
    localparam logic [7:0] ALT     = 8'h11;
    localparam logic [7:0] CAPS    = 8'h58;

    // mods packing is {CAPS, ALT, SHIFT, CTRL}
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [3:0] mods;
    } kb_event_t;

    function automatic logic is_modifier(input logic [7:0] c);
        return (c == LSHIFT) || (c == RSHIFT) || (c == CTRL) || (c == ALT);
    endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// Synchronous FIFO of decoded key events; head entry is read straight from the storage registers.
module kb_event_fifo
    import kb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  kb_event_t din_i,
    input  logic      pop_i,
    output kb_event_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    kb_event_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/kb_event_sequencer.sv
// Drains the PS/2 raw byte FIFO, folds E0/F0 prefixes into key events, tracks modifiers/locks.
// Build option: define KB_REPEAT_FILTER_EN to drop typematic repeat makes entirely.
module kb_event_sequencer
    import kb_pkg::*;
#(
    parameter int EVQ_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             kb_ready,
    input  logic [7:0]       kb_data,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_repeat,
    output logic [3:0]       ev_mods,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

`ifdef KB_REPEAT_FILTER_EN
    localparam bit DROP_REPEATS = 1'b1;
`else
    localparam bit DROP_REPEATS = 1'b0;
`endif

    kb_state_e        state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             ext_pend_q, ext_pend_d;
    logic             brk_pend_q, brk_pend_d;
    logic [8:0]       held_q, held_d;
    logic             lshift_q, lshift_d;
    logic             rshift_q, rshift_d;
    logic             ctrl_q, ctrl_d;
    logic             alt_q, alt_d;
    logic             caps_q, caps_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             ovf_q, ovf_d;

    logic             is_rpt;
    logic [8:0]       key;
    logic             evq_push;
    kb_event_t        evq_din;
    kb_event_t        evq_head;
    logic             evq_full;
    logic             evq_empty;

    assign key = {ext_pend_q, byte_q};

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        held_d      = held_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        ctrl_d      = ctrl_q;
        alt_d       = alt_q;
        caps_d      = caps_q;
        press_cnt_d = press_cnt_q;
        is_rpt      = 1'b0;
        evq_push    = 1'b0;
        evq_din     = '0;

        unique case (state_q)
            IDLE: begin
                // Never pop a raw byte unless there is room for the event it may produce.
                if (kb_ready && !evq_full) begin
                    byte_d  = kb_data;
                    state_d = POP;
                end
            end
            POP: begin
                state_d = DECODE;
            end
            DECODE: begin
                state_d = IDLE;
                if (byte_q == PFX_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == PFX_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (brk_pend_q) begin
                        if (key == held_q) held_d = '0;
                        if (byte_q == LSHIFT) lshift_d = 1'b0;
                        if (byte_q == RSHIFT) rshift_d = 1'b0;
                        if (byte_q == CTRL)   ctrl_d   = 1'b0;
                        if (byte_q == ALT)    alt_d    = 1'b0;
                        evq_push = 1'b1;
                    end else begin
                        is_rpt = (key == held_q);
                        if (!(is_rpt && DROP_REPEATS)) begin
                            if (byte_q == LSHIFT) lshift_d = 1'b1;
                            if (byte_q == RSHIFT) rshift_d = 1'b1;
                            if (byte_q == CTRL)   ctrl_d   = 1'b1;
                            if (byte_q == ALT)    alt_d    = 1'b1;
                            if (!is_rpt) begin
                                held_d = key;
                                if (byte_q == CAPS) begin
                                    caps_d = !caps_q;
                                end else if (!is_modifier(byte_q)) begin
                                    press_cnt_d = press_cnt_q + 1'b1;
                                end
                            end
                            evq_push = 1'b1;
                        end
                    end
                    // Snapshot is taken after this event's own modifier effect.
                    evq_din.code = byte_q;
                    evq_din.ext  = ext_pend_q;
                    evq_din.brk  = brk_pend_q;
                    evq_din.rpt  = is_rpt && !DROP_REPEATS;
                    evq_din.mods = {caps_d, alt_d, lshift_d | rshift_d, ctrl_d};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Overflow set has priority over a simultaneous clear.
    assign ovf_d = kb_overflow ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            held_q      <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            ctrl_q      <= 1'b0;
            alt_q       <= 1'b0;
            caps_q      <= 1'b0;
            press_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            held_q      <= held_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            ctrl_q      <= ctrl_d;
            alt_q       <= alt_d;
            caps_q      <= caps_d;
            press_cnt_q <= press_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    kb_event_fifo #(
        .DEPTH (EVQ_DEPTH)
    ) u_evq (
        .clk     (clk),
        .rst_n   (clrn),
        .push_i  (evq_push),
        .din_i   (evq_din),
        .pop_i   (ev_ready),
        .head_o  (evq_head),
        .full_o  (evq_full),
        .empty_o (evq_empty)
    );

    assign kb_nextdata_n = (state_q != POP);
    assign ev_valid      = !evq_empty;
    assign ev_code       = evq_head.code;
    assign ev_ext        = evq_head.ext;
    assign ev_break      = evq_head.brk;
    assign ev_mods       = evq_head.mods;
    assign press_cnt     = press_cnt_q;
    assign ovf_sticky    = ovf_q;

`ifdef KB_REPEAT_FILTER_EN
    logic unused_rpt;
    assign unused_rpt = evq_head.rpt;
    assign ev_repeat  = 1'b0;
`else
    assign ev_repeat  = evq_head.rpt;
`endif

endmodule
